systolic_tile_scheduler: RTL and testbench
==========================================

Name: systolic_tile_scheduler

Overview:
- Top-level sequencer for the 8x8 systolic array wrapper.
- Polls the scratchpad (SP) BRAM for a start command and loads mode/M/K/N from the SP control words.
- Breaks the padded MxK * KxN GEMM into TILE x TILE tile jobs and issues them one at a time to the array datapath over a valid/ready/done handshake.
- Writes completion status to SP word 100 and waits for the host to clear it.

Parameters:
- TILE, 8, array edge; tile size on M, K and N.
- DIM_W, 16, width of the M/K/N counters and registers.
- MAX_DIM, 256, largest legal M, K or N.
- ADDR_W, 32, byte-address width of SP/A/W/O addresses.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- sp_addr_b  out  ADDR_W  SP port-B byte address.
- sp_wdata_b  out  32  SP port-B write data.
- sp_we_b  out  4  SP port-B byte write enables.
- sp_rdata_b  in  32  SP port-B read data; valid 1 cycle after the address.
- tile_valid  out  1  tile job offered to the array.
- tile_ready  in  1  array accepts the job.
- tile_done  in  1  1-cycle pulse when the accepted job has fully retired.
- tile_mode  out  1  0 = WS, 1 = OS.
- tile_a_base  out  ADDR_W  A BRAM byte address of tile element [0][0].
- tile_w_base  out  ADDR_W  W BRAM byte address of tile element [0][0].
- tile_o_base  out  ADDR_W  O BRAM byte address of tile element [0][0].
- a_stride  out  ADDR_W  A row stride in bytes, K*4.
- wo_stride  out  ADDR_W  W and O row stride in bytes, N*4.
- acc_clear  out  1  first K-slice: overwrite O, do not accumulate.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, and all counters and config registers are cleared. Reset mid-operation abandons the current job immediately; the SP is not written.
- SP map (byte addresses): 0 start, 4 mode, 8 M, 12 K, 16 N, 100 status.
- IDLE: issue a read of address 0 every 2 cycles. If the returned data is nonzero, write 0 to address 0 (we = 4'b1111) and go to CFG.
- CFG: read addresses 4, 8, 12 and 16 back-to-back; each value is captured 1 cycle after its address. Mode uses bit 0; M/K/N use bits [DIM_W-1:0].
- Validation, one cycle after the last capture: error if any of M, K or N is 0, not a multiple of TILE, or greater than MAX_DIM. An error goes to FIN with status 2; otherwise go to ISSUE.
- Loop order:
  - OS: mi outer, ni, ki inner.
  - WS: ki outer, ni, mi inner.
  - Indices step by TILE.
- Base addresses:
  - tile_a_base = (mi*K + ki)*4
  - tile_w_base = (ki*N + ni)*4
  - tile_o_base = (mi*N + ni)*4
  - acc_clear = (ki == 0)
- Base and stride arithmetic is unsigned at ADDR_W bits. The products cannot overflow when dims are at most MAX_DIM.
- ISSUE: assert tile_valid. All tile_* outputs and acc_clear are stable while tile_valid is high. On tile_valid & tile_ready, drop tile_valid the next cycle and go to WAIT.
- WAIT: on tile_done, advance the indices; a tile_done seen in any other state is ignored. If this was the last tile, go to FIN with status 1; else go to ISSUE.
- Minimum gap from tile_done to the next tile_valid is 1 cycle.
- FIN: write the status to address 100 for 1 cycle, then go to HOLD.
- HOLD: read address 100 every 2 cycles. When it reads 0, go to IDLE. A start written during HOLD stays pending in word 0 and is serviced from IDLE.
- SP port B is idle when not accessing: we = 0. Address and data are held.

Optional Feature:
- Macro: SCHED_PERF_CNT_EN.
- When defined: a 32-bit cycle counter clears on entry to CFG and increments every cycle until FIN. FIN takes 2 cycles: it writes the count to address 104, then the status to address 100. The counter saturates at 0xFFFFFFFF.
- When undefined: no counter, address 104 is never written, and FIN takes 1 cycle.

Test Plan:
- OS 8/8/8, start=1 → exactly one job: bases 0/0/0, a_stride 32, wo_stride 32, acc_clear=1. After tile_done: SP[0]=0, SP[100]=1. Bench writes SP[100]=0 → busy falls within 4 cycles.
- OS 16/16/16 with tile_ready tied 1 → 8 jobs in order (mi,ni,ki) = (0,0,0), (0,0,8), (0,8,0), …. Job 2: a_base 32, w_base 512, o_base 0, acc_clear=0.
- WS 16/8/24 → 6 jobs in order (ki,ni,mi) = (0,0,0), (0,0,8), (0,8,0), …. Job 2: a_base 256, w_base 0, o_base 768. All jobs acc_clear=1.
- Backpressure: tile_ready low for 5 cycles → tile_valid is held and the bases stay constant. A stray tile_done pulse in ISSUE is ignored.
- M=7 or K=0 or N=264 → no tile_valid; SP[100]=2 and SP[0]=0.
- Reset asserted in WAIT of job 3 of 16/16/16 → all outputs 0 next cycle and no SP write. A new start then runs all 8 jobs.

Source files
------------

// File: rtl/systolic_tile_scheduler.sv
// rtl/systolic_tile_scheduler.sv - SP-polled GEMM tile job sequencer for the 8x8 systolic array (optional perf counter: SCHED_PERF_CNT_EN)
module systolic_tile_scheduler #(
  parameter int TILE    = 8,
  parameter int DIM_W   = 16,
  parameter int MAX_DIM = 256,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] sp_addr_b,
  output logic [31:0]       sp_wdata_b,
  output logic [3:0]        sp_we_b,
  input  logic [31:0]       sp_rdata_b,
  output logic              tile_valid,
  input  logic              tile_ready,
  input  logic              tile_done,
  output logic              tile_mode,
  output logic [ADDR_W-1:0] tile_a_base,
  output logic [ADDR_W-1:0] tile_w_base,
  output logic [ADDR_W-1:0] tile_o_base,
  output logic [ADDR_W-1:0] a_stride,
  output logic [ADDR_W-1:0] wo_stride,
  output logic              acc_clear,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ADDR_START  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(100);
`ifdef SCHED_PERF_CNT_EN
  localparam logic [ADDR_W-1:0] ADDR_PERF   = ADDR_W'(104);
`endif

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_ISSUE, S_WAIT, S_FIN, S_HOLD} state_t;

  state_t            state, state_n;
  logic              poll, rd_ok, polling, sample;
  logic [2:0]        cfg_cnt;
  logic              mode;
  logic [DIM_W-1:0]  m_dim, k_dim, n_dim;
  logic [DIM_W-1:0]  mi, ni, ki, mi_n, ni_n, ki_n;
  logic [DIM_W-1:0]  mi_step, ni_step, ki_step;
  logic              mi_wrap, ni_wrap, ki_wrap, last_tile, cfg_bad;
  logic [1:0]        status, status_n;
  logic [ADDR_W-1:0] sp_addr_n;
  logic [31:0]       sp_wdata_n;
  logic [3:0]        sp_we_n;
  logic              fin_write;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0]       perf_cnt;
  logic              fin_step;
`endif

  function automatic logic dim_bad(input logic [DIM_W-1:0] d);
    return (d == '0) || ((d % DIM_W'(TILE)) != '0) || (d > DIM_W'(MAX_DIM));
  endfunction

  assign cfg_bad = dim_bad(m_dim) || dim_bad(k_dim) || dim_bad(n_dim);

  // The SP address is held constant while polling, so rdata is valid once the
  // same read has been on the port for a full cycle; poll halves the rate.
  assign polling = (state == S_IDLE) || (state == S_HOLD);
  assign sample  = poll && rd_ok;

  assign mi_step = mi + DIM_W'(TILE);
  assign ni_step = ni + DIM_W'(TILE);
  assign ki_step = ki + DIM_W'(TILE);
  assign mi_wrap = (mi_step == m_dim);
  assign ni_wrap = (ni_step == n_dim);
  assign ki_wrap = (ki_step == k_dim);
  assign last_tile = mi_wrap && ni_wrap && ki_wrap;

  assign busy        = (state != S_IDLE);
  assign tile_valid  = (state == S_ISSUE);
  assign tile_mode   = mode;
  assign acc_clear   = ((state == S_ISSUE) || (state == S_WAIT)) && (ki == '0);
  assign tile_a_base = (ADDR_W'(mi) * ADDR_W'(k_dim) + ADDR_W'(ki)) << 2;
  assign tile_w_base = (ADDR_W'(ki) * ADDR_W'(n_dim) + ADDR_W'(ni)) << 2;
  assign tile_o_base = (ADDR_W'(mi) * ADDR_W'(n_dim) + ADDR_W'(ni)) << 2;
  assign a_stride    = ADDR_W'(k_dim) << 2;
  assign wo_stride   = ADDR_W'(n_dim) << 2;

  // Next tile indices: OS walks ki fastest then ni then mi; WS walks mi, ni, ki
  always_comb begin
    mi_n = mi;
    ni_n = ni;
    ki_n = ki;
    if (mode) begin
      ki_n = ki_wrap ? '0 : ki_step;
      if (ki_wrap) ni_n = ni_wrap ? '0 : ni_step;
      if (ki_wrap && ni_wrap) mi_n = mi_wrap ? '0 : mi_step;
    end else begin
      mi_n = mi_wrap ? '0 : mi_step;
      if (mi_wrap) ni_n = ni_wrap ? '0 : ni_step;
      if (mi_wrap && ni_wrap) ki_n = ki_wrap ? '0 : ki_step;
    end
  end

  // Next state and next SP port contents; the port registers show what each state does
  always_comb begin
    state_n    = state;
    status_n   = status;
    sp_addr_n  = sp_addr_b;
    sp_wdata_n = sp_wdata_b;
    sp_we_n    = 4'b0000;
    fin_write  = 1'b0;
    case (state)
      S_IDLE: begin
        if (sample && (sp_rdata_b != 32'd0)) begin
          state_n    = S_CFG;
          sp_addr_n  = ADDR_START;
          sp_wdata_n = 32'd0;
          sp_we_n    = 4'b1111;
        end
      end
      S_CFG: begin
        if (cfg_cnt < 3'd4) sp_addr_n = ADDR_W'({cfg_cnt + 3'd1, 2'b00});
        if (cfg_cnt == 3'd6) begin
          if (cfg_bad) begin
            state_n   = S_FIN;
            status_n  = 2'd2;
            fin_write = 1'b1;
          end else begin
            state_n = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (tile_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (tile_done) begin
          if (last_tile) begin
            state_n   = S_FIN;
            status_n  = 2'd1;
            fin_write = 1'b1;
          end else begin
            state_n = S_ISSUE;
          end
        end
      end
      S_FIN: begin
`ifdef SCHED_PERF_CNT_EN
        if (!fin_step) begin
          sp_addr_n  = ADDR_STATUS;
          sp_wdata_n = {30'd0, status};
          sp_we_n    = 4'b1111;
        end else begin
          state_n = S_HOLD;
        end
`else
        state_n = S_HOLD;
`endif
      end
      S_HOLD: begin
        if (sample && (sp_rdata_b == 32'd0)) begin
          state_n   = S_IDLE;
          sp_addr_n = ADDR_START;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (fin_write) begin
      sp_we_n = 4'b1111;
`ifdef SCHED_PERF_CNT_EN
      sp_addr_n  = ADDR_PERF;
      sp_wdata_n = perf_cnt;
`else
      sp_addr_n  = ADDR_STATUS;
      sp_wdata_n = {30'd0, status_n};
`endif
    end
  end

  // State, SP port, config capture and tile index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      status     <= 2'd0;
      sp_addr_b  <= '0;
      sp_wdata_b <= 32'd0;
      sp_we_b    <= 4'b0000;
      poll       <= 1'b0;
      rd_ok      <= 1'b0;
      cfg_cnt    <= 3'd0;
      mode       <= 1'b0;
      m_dim      <= '0;
      k_dim      <= '0;
      n_dim      <= '0;
      mi         <= '0;
      ni         <= '0;
      ki         <= '0;
    end else begin
      state      <= state_n;
      status     <= status_n;
      sp_addr_b  <= sp_addr_n;
      sp_wdata_b <= sp_wdata_n;
      sp_we_b    <= sp_we_n;
      poll       <= (polling && (state_n == state)) ? ~poll : 1'b0;
      rd_ok      <= polling && (state_n == state) && (sp_we_b == 4'b0000);
      cfg_cnt    <= (state == S_CFG) ? cfg_cnt + 3'd1 : 3'd0;
      if (state == S_CFG) begin
        case (cfg_cnt)
          3'd2:    mode  <= sp_rdata_b[0];
          3'd3:    m_dim <= sp_rdata_b[DIM_W-1:0];
          3'd4:    k_dim <= sp_rdata_b[DIM_W-1:0];
          3'd5:    n_dim <= sp_rdata_b[DIM_W-1:0];
          default: ;
        endcase
        mi <= '0;
        ni <= '0;
        ki <= '0;
      end else if ((state == S_WAIT) && tile_done) begin
        mi <= mi_n;
        ni <= ni_n;
        ki <= ki_n;
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  // Saturating cycle count from CFG entry until FIN; fin_step splits FIN into two writes
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cnt <= 32'd0;
      fin_step <= 1'b0;
    end else begin
      fin_step <= (state == S_FIN);
      if ((state == S_IDLE) && (state_n == S_CFG)) begin
        perf_cnt <= 32'd0;
      end else if (((state == S_CFG) || (state == S_ISSUE) || (state == S_WAIT)) &&
                   (perf_cnt != 32'hFFFF_FFFF)) begin
        perf_cnt <= perf_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// tb/tb_systolic_tile_scheduler.sv - self-checking bench for systolic_tile_scheduler
module tb_systolic_tile_scheduler;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] o;
    logic        clr;
  } job_t;

  logic        clk;
  logic        reset;
  logic [31:0] sp_addr_b;
  logic [31:0] sp_wdata_b;
  logic [3:0]  sp_we_b;
  logic [31:0] sp_rdata_b;
  logic        tile_valid;
  logic        tile_ready;
  logic        tile_done;
  logic        tile_mode;
  logic [31:0] tile_a_base;
  logic [31:0] tile_w_base;
  logic [31:0] tile_o_base;
  logic [31:0] a_stride;
  logic [31:0] wo_stride;
  logic        acc_clear;
  logic        busy;

  bit   [31:0] mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_addr;
  logic [31:0] bd_data;

  int vectors;
  int miscompares;

  systolic_tile_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .sp_addr_b   (sp_addr_b),
    .sp_wdata_b  (sp_wdata_b),
    .sp_we_b     (sp_we_b),
    .sp_rdata_b  (sp_rdata_b),
    .tile_valid  (tile_valid),
    .tile_ready  (tile_ready),
    .tile_done   (tile_done),
    .tile_mode   (tile_mode),
    .tile_a_base (tile_a_base),
    .tile_w_base (tile_w_base),
    .tile_o_base (tile_o_base),
    .a_stride    (a_stride),
    .wo_stride   (wo_stride),
    .acc_clear   (acc_clear),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratchpad BRAM: read-first, one-cycle read latency, plus a bench backdoor write port
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (sp_we_b[b]) mem[sp_addr_b[7:2]][8*b +: 8] <= sp_wdata_b[8*b +: 8];
    if (bd_we) mem[bd_addr] <= bd_data;
    sp_rdata_b <= mem[sp_addr_b[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input int word, input logic [31:0] data);
    @(negedge clk);
    bd_addr = 6'(word);
    bd_data = data;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic check_quiet(input string pfx);
    chk({pfx, "_busy"},  32'(busy), 32'd0);
    chk({pfx, "_valid"}, 32'(tile_valid), 32'd0);
    chk({pfx, "_we"},    32'(sp_we_b), 32'd0);
    chk({pfx, "_addr"},  sp_addr_b, 32'd0);
    chk({pfx, "_wdata"}, sp_wdata_b, 32'd0);
    chk({pfx, "_abase"}, tile_a_base | tile_w_base | tile_o_base, 32'd0);
    chk({pfx, "_strd"},  a_stride | wo_stride, 32'd0);
    chk({pfx, "_clr"},   32'(acc_clear), 32'd0);
    chk({pfx, "_mode"},  32'(tile_mode), 32'd0);
  endtask

  // rdy_mode: 0 ready tied high, 1 random ready, 2 ready low 5 cycles per job with a stray done
  task automatic run_gemm(input logic md, input int m, input int k, input int n,
                          input int rdy_mode, input int abort_after);
    job_t        exp_q[$];
    job_t        j;
    int          got, done_timer, hold_cnt;
    bit          err_cfg, fin_seen, aborted, held, dropped;
    logic [31:0] st, exp_st;

    err_cfg = (m == 0) || (m % 8 != 0) || (m > 256) ||
              (k == 0) || (k % 8 != 0) || (k > 256) ||
              (n == 0) || (n % 8 != 0) || (n > 256);
    if (!err_cfg) begin
      if (md) begin
        for (int mi = 0; mi < m; mi += 8)
          for (int ni = 0; ni < n; ni += 8)
            for (int ki = 0; ki < k; ki += 8) begin
              j.a = 32'((mi * k + ki) * 4); j.w = 32'((ki * n + ni) * 4);
              j.o = 32'((mi * n + ni) * 4); j.clr = (ki == 0);
              exp_q.push_back(j);
            end
      end else begin
        for (int ki = 0; ki < k; ki += 8)
          for (int ni = 0; ni < n; ni += 8)
            for (int mi = 0; mi < m; mi += 8) begin
              j.a = 32'((mi * k + ki) * 4); j.w = 32'((ki * n + ni) * 4);
              j.o = 32'((mi * n + ni) * 4); j.clr = (ki == 0);
              exp_q.push_back(j);
            end
      end
    end
    exp_st = err_cfg ? 32'd2 : 32'd1;

    bd_write(1, {31'd0, md});
    bd_write(2, 32'(m));
    bd_write(3, 32'(k));
    bd_write(4, 32'(n));
    bd_write(25, 32'd0);
    bd_write(0, 32'($urandom_range(1, 255)));

    got = 0; done_timer = -1; hold_cnt = 0;
    fin_seen = 0; aborted = 0; held = 0; st = 32'd0;
    for (int cyc = 0; cyc < 4000 && !fin_seen && !aborted; cyc++) begin
      @(negedge clk);
      tile_done = 1'b0;
      if (done_timer == 0) begin
        tile_done  = 1'b1;
        done_timer = -1;
      end else if (done_timer > 0) begin
        done_timer--;
      end
      if ((sp_we_b != 4'd0) && (sp_addr_b == 32'd100)) begin
        fin_seen = 1;
        st = sp_wdata_b;
      end
      if (held) begin
        chk("hold_valid", 32'(tile_valid), 32'd1);
        if (got < exp_q.size()) begin
          chk("hold_a", tile_a_base, exp_q[got].a);
          chk("hold_o", tile_o_base, exp_q[got].o);
        end
      end
      if (tile_valid) begin
        case (rdy_mode)
          0: tile_ready = 1'b1;
          1: tile_ready = ($urandom_range(0, 2) != 0);
          default: begin
            tile_ready = (hold_cnt >= 5);
            if (hold_cnt == 2) tile_done = 1'b1;
            hold_cnt++;
          end
        endcase
        if (tile_ready) begin
          if (got < exp_q.size()) begin
            chk("job_a",    tile_a_base, exp_q[got].a);
            chk("job_w",    tile_w_base, exp_q[got].w);
            chk("job_o",    tile_o_base, exp_q[got].o);
            chk("job_clr",  32'(acc_clear), 32'(exp_q[got].clr));
            chk("job_mode", 32'(tile_mode), 32'(md));
            chk("a_stride", a_stride, 32'(k * 4));
            chk("wo_strd",  wo_stride, 32'(n * 4));
          end else begin
            chk("extra_job", 32'(got), 32'(exp_q.size()));
          end
          got++;
          hold_cnt   = 0;
          done_timer = int'($urandom_range(0, 3));
          held       = 0;
          if ((abort_after != 0) && (got == abort_after)) begin
            @(negedge clk);
            tile_ready = 1'b0;
            tile_done  = 1'b0;
            reset      = 1'b1;
            @(negedge clk);
            check_quiet("abort");
            reset = 1'b0;
            @(negedge clk);
            chk("abort_status_word", mem[25], 32'd0);
            aborted = 1;
          end
        end else begin
          held = 1;
        end
      end else begin
        held = 0;
        tile_ready = (rdy_mode == 0) ? 1'b1 : ((rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      end
    end
    tile_done = 1'b0;

    if (!aborted) begin
      chk("fin_seen",  32'(fin_seen), 32'd1);
      chk("status_wr", st, exp_st);
      chk("job_count", 32'(got), 32'(exp_q.size()));
      repeat (4) @(negedge clk);
      chk("hold_busy",   32'(busy), 32'd1);
      chk("start_clear", mem[0], 32'd0);
      chk("status_word", mem[25], exp_st);
      @(negedge clk);
      bd_addr = 6'd25; bd_data = 32'd0; bd_we = 1'b1;
      @(negedge clk);
      bd_we = 1'b0;
      dropped = 0;
      for (int i = 0; i < 3 && !dropped; i++) begin
        @(negedge clk);
        if (!busy) dropped = 1;
      end
      chk("busy_release", 32'(dropped), 32'd1);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; tile_ready = 1'b0; tile_done = 1'b0;
    bd_we = 1'b0; bd_addr = 6'd0; bd_data = 32'd0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;

    run_gemm(1'b1, 8, 8, 8, 1, 0);
    run_gemm(1'b1, 16, 16, 16, 0, 0);
    run_gemm(1'b0, 16, 8, 24, 1, 0);
    run_gemm(1'b0, 16, 16, 8, 2, 0);
    run_gemm(1'b1, 7, 8, 8, 1, 0);
    run_gemm(1'b1, 8, 0, 8, 1, 0);
    run_gemm(1'b0, 8, 8, 264, 1, 0);
    run_gemm(1'b1, 16, 16, 16, 0, 3);
    run_gemm(1'b1, 16, 16, 16, 0, 0);
    for (int r = 0; r < 4; r++)
      run_gemm(1'($urandom_range(0, 1)), 8 * int'($urandom_range(1, 3)),
               8 * int'($urandom_range(1, 3)), 8 * int'($urandom_range(1, 3)), 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
